fifo_write_arbiter: RTL

Round-robin write-side arbiter that shares one `fifo_design` instance between `NUM_REQ` producers. Each producer presents words on a valid/ack handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `en_write`/`data_in` directly. It respects `full_fifo` back-pressure, so no word is ever dropped or duplicated.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // Width of a producer index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester after last_winner, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [idx_width(NUM_REQ)-1:0]   last_winner,
   output logic [idx_width(NUM_REQ)-1:0]   pick,
   output logic                            any
);

   localparam int unsigned IW = idx_width(NUM_REQ);

   assign any = |req_valid;

   // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
   always_comb begin
      int unsigned idx;
      pick = '0;
      idx  = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_winner) + k) % NUM_REQ;
         if (req_valid[idx]) pick = IW'(idx);
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ producers.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATAWIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]              req_ack,
   input  logic                            fifo_full,
   output logic                            fifo_en_write,
   output logic [DATAWIDTH-1:0]            fifo_data_in,
   output logic [idx_width(NUM_REQ)-1:0]   owner,
   output logic                            busy
);

   localparam int unsigned IW = idx_width(NUM_REQ);
   localparam int unsigned BW = $clog2(BURST_LEN + 1);

   arb_state_t      state;
   logic [IW-1:0]   last_winner;
   logic [BW-1:0]   bcnt;
   logic [IW-1:0]   pick;
   logic            any;
   logic            ack;
   logic            release_grant;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_valid   (req_valid),
      .last_winner (last_winner),
      .pick        (pick),
      .any         (any)
   );

   // Only the current owner may be acked, and only while the FIFO has room.
   always_comb begin
      req_ack = '0;
      if (state == GRANT && !fifo_full) req_ack[owner] = req_valid[owner];
   end

   assign ack           = |req_ack;
   assign fifo_en_write = ack;
   assign busy          = (state == GRANT);

   // Release when the owner drops valid or its burst quota is used up.
   assign release_grant = !req_valid[owner] || (ack && bcnt == BW'(BURST_LEN - 1));

   // Data mux: owner's slice while granted, zero otherwise.
   always_comb begin
      fifo_data_in = '0;
      if (state == GRANT) fifo_data_in = req_data[owner*DATAWIDTH +: DATAWIDTH];
   end

   // Grant FSM with burst counter; release re-arbitrates on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= '0;
         last_winner <= IW'(NUM_REQ - 1);
         bcnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  state       <= GRANT;
                  owner       <= pick;
                  last_winner <= pick;
                  bcnt        <= '0;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  bcnt <= '0;
                  if (any) begin
                     owner       <= pick;
                     last_winner <= pick;
                  end else begin
                     state <= IDLE;
                  end
               end else if (ack) begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
